mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_ram.sv | 33 +++
 rtl/mem_ctrl.sv | 107 ++++++++++
 tb/tb_mem_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-stated memory controller:
// FSM state encoding and default geometry/timing constants.
package mem_pkg;

    localparam int ADDR_W_DEF      = 9;
    localparam int WORD_W_DEF      = 32;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_ram.sv
// Synchronous single-port RAM with write enable and an enabled, clearable
// read register; the array itself is never reset.
module mem_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only moves on reads so it holds the last read word.
    always_ff @(posedge clock) begin
        if (clear) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Wait-stated memory controller between the MAR/MDR and a single-port RAM.
// Define MEM_PARITY_EN to store an even-parity bit per word and flag perr.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WORD_W      = WORD_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] MARout,
    input  logic [WORD_W-1:0] MDRout,
    output logic [WORD_W-1:0] Mdatain,
    output logic              Read,
    output logic              busy,
    output logic              done,
    output logic              perr
);

`ifdef MEM_PARITY_EN
    localparam int DW = WORD_W + 1;
`else
    localparam int DW = WORD_W;
`endif

    state_t            state;
    logic [2:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              we;
    logic              re;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= 3'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACCESS: state <= DONE;
                DONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A simultaneous read/write request is served as a read only.
    always_ff @(posedge clock) begin
        if (state == IDLE && (rd_req || wr_req)) begin
            addr  <= MARout;
            wdata <= MDRout;
            op_wr <= wr_req & ~rd_req;
        end
    end

    assign we = (state == ACCESS) && op_wr && !clear;
    assign re = (state == ACCESS) && !op_wr;

`ifdef MEM_PARITY_EN
    assign ram_wdata = {^wdata, wdata};
    assign perr      = ^ram_rdata;
`else
    assign ram_wdata = wdata;
    assign perr      = 1'b0;
`endif

    mem_ram #(
        .AW (ADDR_W),
        .DW (DW)
    ) u_ram (
        .clock (clock),
        .clear (clear),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign Mdatain = ram_rdata[WORD_W-1:0];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign Read    = (state == DONE) && !op_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl: one instance with two wait
// states and one with none; build with MEM_PARITY_EN to cover parity.
module tb_mem_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        rd_req, wr_req;
    logic [8:0]  MARout;
    logic [31:0] MDRout;
    logic [31:0] Mdatain;
    logic        Read, busy, done, perr;

    logic        rd_req0, wr_req0;
    logic [8:0]  MARout0;
    logic [31:0] MDRout0;
    logic [31:0] Mdatain0;
    logic        Read0, busy0, done0, perr0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;

    always #5 clock = ~clock;

    mem_ctrl #(.ADDR_W(9), .WORD_W(32), .WAIT_CYCLES(2)) dut (
        .clock   (clock),
        .clear   (clear),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .MARout  (MARout),
        .MDRout  (MDRout),
        .Mdatain (Mdatain),
        .Read    (Read),
        .busy    (busy),
        .done    (done),
        .perr    (perr)
    );

    mem_ctrl #(.ADDR_W(9), .WORD_W(32), .WAIT_CYCLES(0)) dut0 (
        .clock   (clock),
        .clear   (clear),
        .rd_req  (rd_req0),
        .wr_req  (wr_req0),
        .MARout  (MARout0),
        .MDRout  (MDRout0),
        .Mdatain (Mdatain0),
        .Read    (Read0),
        .busy    (busy0),
        .done    (done0),
        .perr    (perr0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d);
        @(negedge clock);
        rd_req = rd;
        wr_req = wr;
        MARout = a;
        MDRout = d;
        @(posedge clock);
    endtask

    // Counts negedges after the accept edge until done; flags stray
    // Read or idle cycles seen before done.
    task automatic wait_done(output int lat, output int bad);
        lat = 0;
        bad = 0;
        do begin
            @(negedge clock);
            lat++;
            rd_req = 1'b0;
            wr_req = 1'b0;
            if (!done && Read) bad++;
            if (!done && !busy) bad++;
        end while (!done && lat < 20);
    endtask

    task automatic xfer(input string tag, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        int lat, bad;
        issue(rd, wr, a, d);
        wait_done(lat, bad);
        if (rd) last_rd = exp;
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " ctl"}, 32'(bad), 32'd0);
        check({tag, " Read"}, {31'd0, Read}, {31'd0, rd});
        check({tag, " data"}, Mdatain, last_rd);
    endtask

    initial begin
        int lat, bad, pulses, first, idles;
        clear   = 1'b1;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        MARout  = '0;
        MDRout  = '0;
        rd_req0 = 1'b0;
        wr_req0 = 1'b0;
        MARout0 = '0;
        MDRout0 = '0;
        last_rd = 32'd0;
        repeat (2) @(negedge clock);
        check("rst Mdatain", Mdatain, 32'd0);
        check("rst Read", {31'd0, Read}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst perr", {31'd0, perr}, 32'd0);
        check("rst busy0", {31'd0, busy0}, 32'd0);
        clear = 1'b0;

        xfer("pre010", 1'b0, 1'b1, 9'h010, 32'h12345678, 32'd0);
        xfer("pre1ff", 1'b0, 1'b1, 9'h1FF, 32'h11111111, 32'd0);

        xfer("wr0a5", 1'b0, 1'b1, 9'h0A5, 32'hDEADBEEF, 32'd0);
        xfer("rd0a5", 1'b1, 1'b0, 9'h0A5, 32'h0, 32'hDEADBEEF);
        check("rd0a5 perr", {31'd0, perr}, 32'd0);

        xfer("both010", 1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, 32'h12345678);
        xfer("rd010", 1'b1, 1'b0, 9'h010, 32'h0, 32'h12345678);

        // clear during WAIT aborts the write
        issue(1'b0, 1'b1, 9'h1FF, 32'hCAFEF00D);
        @(negedge clock);
        wr_req = 1'b0;
        check("rstwait busy", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        last_rd = 32'd0;
        check("rstwait busy0", {31'd0, busy}, 32'd0);
        check("rstwait done", {31'd0, done}, 32'd0);
        check("rstwait Read", {31'd0, Read}, 32'd0);
        check("rstwait data", Mdatain, 32'd0);
        xfer("rd1ff", 1'b1, 1'b0, 9'h1FF, 32'h0, 32'h11111111);

        // clear during ACCESS suppresses the RAM write
        issue(1'b0, 1'b1, 9'h0A5, 32'h55555555);
        @(negedge clock);
        wr_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rstacc busy", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        last_rd = 32'd0;
        check("rstacc busy0", {31'd0, busy}, 32'd0);
        check("rstacc data", Mdatain, 32'd0);
        xfer("rdacc", 1'b1, 1'b0, 9'h0A5, 32'h0, 32'hDEADBEEF);

        xfer("wr077", 1'b0, 1'b1, 9'h077, 32'h0F0F1234, 32'hDEADBEEF);
        xfer("rd077", 1'b1, 1'b0, 9'h077, 32'h0, 32'h0F0F1234);

`ifdef MEM_PARITY_EN
        xfer("pwr020", 1'b0, 1'b1, 9'h020, 32'h00000001, 32'h0F0F1234);
        dut.u_ram.mem[9'h020][32] = ~dut.u_ram.mem[9'h020][32];
        issue(1'b1, 1'b0, 9'h020, 32'h0);
        wait_done(lat, bad);
        check("par bad done", {31'd0, done}, 32'd1);
        check("par bad perr", {31'd0, perr}, 32'd1);
        issue(1'b1, 1'b0, 9'h077, 32'h0);
        wait_done(lat, bad);
        check("par ok perr", {31'd0, perr}, 32'd0);
        check("par ok data", Mdatain, 32'h0F0F1234);
`endif

        // zero wait states: write, then hold rd_req high
        @(negedge clock);
        wr_req0 = 1'b1;
        MARout0 = 9'h003;
        MDRout0 = 32'hA5A5A5A5;
        @(posedge clock);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            wr_req0 = 1'b0;
        end while (!done0 && lat < 20);
        check("z wr latency", 32'(lat), 32'd2);
        @(negedge clock);
        rd_req0 = 1'b1;
        pulses = 0;
        first  = 0;
        idles  = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (done0) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (!busy0) idles++;
        end
        rd_req0 = 1'b0;
        check("z first done", 32'(first), 32'd2);
        check("z pulses", 32'(pulses), 32'd4);
        check("z idles", 32'(idles), 32'd4);
        check("z data", Mdatain0, 32'hA5A5A5A5);
        check("z perr", {31'd0, perr0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
